// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // Two-bit arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SERVE_I = 2'b01,
        ST_SERVE_D = 2'b10,
        ST_DONE    = 2'b11
    } arb_state_t;

    // Owner encoding on GRANT; also the select value of the address mux
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_mux32.sv
// 32-bit 2:1 multiplexer; select = 0 passes in0, select = 1 passes in1.
module mux32
    import mem_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic              select,
    output logic [DATA_W-1:0] result
);

    // Pure combinational selection
    always_comb begin
        result = select ? in1 : in0;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single memory port between an instruction-side reader and a
// data-side reader/writer. Simultaneous requests alternate, starting with the
// instruction side after reset. Each access holds the port for at least two
// cycles and ends in a one-cycle DONE that releases the owner's stall.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic              m_busywait,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writedata,
    output logic              i_busywait,
    output logic              d_busywait,
    output logic [DATA_W-1:0] i_readdata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              grant
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last;       // side served most recently
    logic              first_cyc;  // high during the first cycle of a SERVE
    logic              op_wr;      // data-side access is a write (latched at grant)
    logic [DATA_W-1:0] cap_data;   // read data captured at the end of SERVE
    logic              i_req;
    logic              d_req;
    logic              serving;

    assign i_req       = i_read;
    assign d_req       = d_read | d_write;
    assign serving     = (state == ST_SERVE_I) || (state == ST_SERVE_D);
    assign m_writedata = d_writedata;
    assign i_readdata  = cap_data;
    assign d_readdata  = cap_data;

    // Address path follows the current owner
    mux32 u_addr_mux (
        .in0    (i_address),
        .in1    (d_address),
        .select (grant),
        .result (m_address)
    );

    // Next-state selection, memory strobes and requester stalls
    always_comb begin
        state_nxt  = state;
        m_read     = 1'b0;
        m_write    = 1'b0;
        i_busywait = i_req;
        d_busywait = d_req;
        case (state)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    state_nxt = (last == GRANT_I) ? ST_SERVE_D : ST_SERVE_I;
                end else if (i_req) begin
                    state_nxt = ST_SERVE_I;
                end else if (d_req) begin
                    state_nxt = ST_SERVE_D;
                end
            end
            ST_SERVE_I: begin
                // The instruction side only ever reads
                m_read = 1'b1;
                if (!first_cyc && !m_busywait) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_SERVE_D: begin
                // Strobe was latched at grant so a dropped request still completes
                m_write = op_wr;
                m_read  = !op_wr;
                if (!first_cyc && !m_busywait) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (last == GRANT_I) begin
                    i_busywait = 1'b0;
                end else begin
                    d_busywait = 1'b0;
                end
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, ownership and captured read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            last      <= GRANT_D;
            grant     <= GRANT_I;
            cap_data  <= '0;
            first_cyc <= 1'b0;
            op_wr     <= 1'b0;
        end else begin
            state     <= state_nxt;
            first_cyc <= (state == ST_IDLE) && (state_nxt != ST_IDLE);
            if (state == ST_IDLE && state_nxt == ST_SERVE_I) begin
                grant <= GRANT_I;
            end
            if (state == ST_IDLE && state_nxt == ST_SERVE_D) begin
                grant <= GRANT_D;
                // Write wins when both data strobes are up
                op_wr <= d_write;
            end
            if (serving && state_nxt == ST_DONE) begin
                cap_data <= m_readdata;
                last     <= grant;
            end
        end
    end

endmodule
